lsu_st_req_queue: RTL
=====================

// Module: lsu_st_req_queue
// PURPOSE
//  Fall-through request queue directly upstream of the store unit. Buffers store/AMO
//  requests issued by the LSU while the store unit stalls (address translation miss,
//  store/AMO buffer full) and presents them one at a time. The store unit consumes the head
//  with its pop strobe. With the queue empty, a pushed request is visible combinationally in
//  the same cycle, so the idle path adds zero latency.
// PARAMETERS
//  DEPTH      2    entries; power of two, >=2
//  CTRL_W     160  width of packed lsu_ctrl_t request word
//  CNT_W      $clog2(DEPTH+1)  occupancy counter width (derived, do not override)
// PORTS
//  clk_i      in   1       clock
//  rst_ni     in   1       asynchronous reset, active-low
//  flush_i    in   1       pipeline flush; discards all queued requests
//  push_i     in   1       request valid from LSU issue
//  req_i      in   CTRL_W  request word (packed lsu_ctrl_t)
//  full_o     out  1       queue full; LSU must not push (registered-count based)
//  valid_o    out  1       head request valid towards store unit
//  req_o      out  CTRL_W  head request word
//  pop_i      in   1       store unit consumed head this cycle
//  count_o    out  CNT_W   number of stored entries (excludes fall-through)
// BEHAVIOUR
//  - Storage: DEPTH x CTRL_W register array, read ptr rd_q, write ptr wr_q, count_q.
//    Pointers wrap modulo DEPTH (plain increment, power-of-two width).
//  - Reset: rd_q=wr_q=0, count_q=0; outputs full_o=0, valid_o=push_i (0 with no push),
//    count_o=0. Array contents not reset (don't-care).
//  - Output mux: count_q!=0 -> valid_o=1, req_o=mem[rd_q]; count_q==0 -> valid_o=push_i,
//    req_o=req_i (fall-through).
//  - Cycle update (flush_i=0):
//    empty, push, pop      : nothing stored, count stays 0 (bypass consumed).
//    empty, push, no pop   : write mem[wr_q], wr_q++, count=1; head visible next cycle
//                            from storage (same data as fall-through, no glitch).
//    nonempty, push & pop  : write mem[wr_q], wr_q++, rd_q++, count unchanged.
//    nonempty, push only   : write, wr_q++, count++.
//    nonempty, pop only    : rd_q++, count--.
//    pop with valid_o=0    : ignored (no pointer change).
//  - full_o = (count_q==DEPTH). Push while full_o=1 and no pop is a protocol violation:
//    request dropped, assertion fires. Push while full with pop same cycle is accepted.
//  - flush_i=1: valid_o forced 0; next state rd_q=wr_q=0, count_q=0; push_i and pop_i in
//    flush cycle ignored (push dropped). Takes priority over every other event.
//  - Ordering: strict FIFO; the store unit relies on in-order store issue for commit order.
//  - No combinational path from pop_i to valid_o/req_o/full_o; push_i->valid_o/req_o only
//    when empty (bypass).
//  - Assertions: count_q<=DEPTH; !(push_i && full_o && !pop_i); req_o stable while
//    valid_o && !pop_i && !flush_i.
// TESTING
//  - Bypass: empty, push A with pop same cycle -> valid_o=1, req_o=A same cycle, count_o
//    stays 0.
//  - Stall fill: DEPTH=2, push A,B without pop -> count_o 1 then 2, full_o=1, req_o=A; pop
//    twice -> A then B, count_o 0, valid_o=0.
//  - Simultaneous push/pop at full: count 2, push C + pop -> head B, count_o stays 2,
//    full_o stays 1; wrap-around order A,B,C preserved over 5 ops.
//  - Flush: queue holding 2 entries, flush_i with push D -> next cycle count_o=0,
//    valid_o=0, D never appears.
//  - Reset mid-operation: assert rst_ni=0 with 1 entry -> outputs immediately valid_o=0,
//    count_o=0, full_o=0; first push after release bypasses correctly.
//  - Random push/pop/flush 10k cycles vs. reference FIFO model, never pushing while full
//    -> zero mismatches, no assertion failures.

Source files
------------

// File: rtl/lsu_st_req_if.sv
// Request/response bundle between LSU issue, the store request queue and the
// store unit.
//   slave  : queue side (accepts pushes, presents head, takes pop)
//   master : driver side (LSU issue + store unit, or a testbench)
// Signals: flush_i (discard all), push_i/req_i (request in), full_o (no room),
//          valid_o/req_o (head out), pop_i (head consumed), count_o (stored entries).
interface lsu_st_req_if #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CTRL_W = 160
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              flush_i;
  logic              push_i;
  logic [CTRL_W-1:0] req_i;
  logic              full_o;
  logic              valid_o;
  logic [CTRL_W-1:0] req_o;
  logic              pop_i;
  logic [CNT_W-1:0]  count_o;

  modport slave (
    input  flush_i, push_i, req_i, pop_i,
    output full_o, valid_o, req_o, count_o
  );

  modport master (
    output flush_i, push_i, req_i, pop_i,
    input  full_o, valid_o, req_o, count_o
  );
endinterface

// File: rtl/lsu_st_req_queue.sv
// Fall-through store/AMO request queue in front of the store unit.
// Holds requests while the store unit stalls and presents them in order. When
// empty, a pushed request is forwarded combinationally to the head (zero-latency
// idle path); if it is also popped that cycle nothing is stored.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   q       lsu_st_req_if.slave: flush_i, push_i, req_i, pop_i in;
//           full_o, valid_o, req_o, count_o out
module lsu_st_req_queue #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CTRL_W = 160
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  lsu_st_req_if.slave  q
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][CTRL_W-1:0] mem_q;
  logic [PTR_W-1:0]             rd_q, wr_q;
  logic [CNT_W-1:0]             count_q, count_d;

  logic empty, full, do_pop, do_push, wr_en, rd_adv;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Head mux: storage when occupied, otherwise fall through from the LSU.
  assign q.valid_o = !q.flush_i && (empty ? q.push_i : 1'b1);
  assign q.req_o   = empty ? q.req_i : mem_q[rd_q];
  assign q.full_o  = full;
  assign q.count_o = count_q;

  // valid_o already folds in flush, so a pop during flush is ignored here.
  assign do_pop  = q.pop_i && q.valid_o;
  // A push into a full queue is only legal when the head leaves this cycle.
  assign do_push = q.push_i && !q.flush_i && (!full || q.pop_i);
  // Bypass consumed: an empty-queue push that is popped at once is never stored.
  assign wr_en   = do_push && !(empty && do_pop);
  assign rd_adv  = do_pop && !empty;

  always_comb begin
    count_d = count_q;
    if (q.flush_i) count_d = '0;
    else           count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_adv);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (q.flush_i) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (wr_en)  wr_q <= wr_q + PTR_W'(1);
        if (rd_adv) rd_q <= rd_q + PTR_W'(1);
      end
    end
  end

  // Payload storage is not reset; valid state lives in count_q only.
  // At full with a pop, wr_q == rd_q: the head is read this cycle and
  // overwritten at the edge, which is safe.
  always_ff @(posedge clk_i) begin
    if (!q.flush_i && wr_en) mem_q[wr_q] <= q.req_i;
  end

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CNT_W'(DEPTH)) else $error("count_q exceeds DEPTH");
  a_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(q.push_i && q.full_o && !q.pop_i)) else $error("push while full");
  a_head_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (q.valid_o && !q.pop_i && !q.flush_i) |=> $stable(q.req_o))
    else $error("head changed while stalled");
`endif
endmodule
